alu_control_mul_seq: RTL and testbench

//  Next-generation ALU control for the MIPS datapath. It decodes ALUOp/Funct into the
//  ALU control code, jr and sign, combinationally, exactly as the decode stage expects.
//  It adds a parametrised iterative multiplier sequencer for MULT (Funct 24). The

---
 rtl/alu_control_mul_seq_if.sv | 34 +++
 rtl/alu_control_mul_seq.sv | 186 ++++++++++++++++++
 tb/tb_alu_control_mul_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_mul_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_control_mul_seq_if
// Brief   : Decode-stage bus between control unit, ALU control and HI/LO path.
// Revision: 1.0
// ============================================================================
interface alu_control_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic                 valid_in;
  logic                 flush;
  logic [1:0]           ALUOp;
  logic [5:0]           Funct;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [3:0]           alucontrol;
  logic                 jr;
  logic                 sign;
  logic                 illegal;
  logic                 stall;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_result;

  modport master (
    output valid_in, flush, ALUOp, Funct, a, b,
    input  alucontrol, jr, sign, illegal, stall, mul_done, mul_result
  );

  modport slave (
    input  valid_in, flush, ALUOp, Funct, a, b,
    output alucontrol, jr, sign, illegal, stall, mul_done, mul_result
  );
endinterface
`default_nettype wire

// File: rtl/alu_control_mul_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_control_mul_seq
// Brief   : MIPS ALU control decode plus iterative shift-add MULT sequencer.
// Revision: 1.0
// ============================================================================
module alu_control_mul_seq #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SIGNED_MUL     = 1
) (
  input  wire logic              clk,
  input  wire logic              reset,
  alu_control_mul_seq_if.slave   bus
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam int MW    = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [MW-1:0]    r_mplier;
  logic             r_neg;
  logic [PW-1:0]    r_result;

  logic [3:0]       w_alucontrol;
  logic             w_jr;
  logic             w_sign;
  logic             w_illegal;
  logic             w_mul_req;
  logic [MW-1:0]    w_a_ext;
  logic [MW-1:0]    w_b_ext;
  logic [MW-1:0]    w_a_mag;
  logic [MW-1:0]    w_b_mag;
  logic             w_neg;
  logic [PW-1:0]    w_acc_next;
  logic [PW-1:0]    w_prod;
  logic             w_stall;
  logic             w_mul_done;

  // ---------------------------------------------------------------- decode
  always_comb begin
    w_alucontrol = 4'b0010;
    w_jr         = 1'b0;
    w_illegal    = 1'b0;
    w_sign       = (bus.ALUOp != 2'b11);
    case (bus.ALUOp)
      2'b00: w_alucontrol = 4'b0010;
      2'b01: w_alucontrol = 4'b0110;
      2'b11: w_alucontrol = 4'b0000;
      default: begin
        case (bus.Funct)
          6'd32:   w_alucontrol = 4'b0010;
          6'd34:   w_alucontrol = 4'b0110;
          6'd36:   w_alucontrol = 4'b0000;
          6'd37:   w_alucontrol = 4'b0001;
          6'd39:   w_alucontrol = 4'b1100;
          6'd42:   w_alucontrol = 4'b0111;
          6'd0:    w_alucontrol = 4'b0011;
          6'd24:   w_alucontrol = 4'b1111;
          6'd8: begin
            w_alucontrol = 4'b0010;
            w_jr         = 1'b1;
          end
          default: begin
            w_alucontrol = 4'b0010;
            w_illegal    = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign w_mul_req = bus.valid_in && (bus.ALUOp == 2'b10) && (bus.Funct == 6'd24);

  // One extra bit keeps the magnitude of the most-negative operand representable.
  assign w_a_ext = (SIGNED_MUL != 0) ? {bus.a[WIDTH-1], bus.a} : {1'b0, bus.a};
  assign w_b_ext = (SIGNED_MUL != 0) ? {bus.b[WIDTH-1], bus.b} : {1'b0, bus.b};
  assign w_a_mag = ((SIGNED_MUL != 0) && bus.a[WIDTH-1]) ? -w_a_ext : w_a_ext;
  assign w_b_mag = ((SIGNED_MUL != 0) && bus.b[WIDTH-1]) ? -w_b_ext : w_b_ext;
  assign w_neg   = (SIGNED_MUL != 0) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);

  always_comb begin
    w_acc_next = r_acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_mplier[i]) begin
        w_acc_next = w_acc_next + (r_mcand << i);
      end
    end
  end

  assign w_prod = r_neg ? -r_acc : r_acc;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_mul_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_mul_req;
        if (w_mul_req) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == CNT_W'(N - 1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_mul_done  = !bus.flush;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else if (!bus.flush) begin
      case (r_state)
        S_IDLE: begin
          if (w_mul_req) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{(PW - MW){1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= w_neg;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        S_DONE: begin
          r_result <= w_prod;
        end
        default: ;
      endcase
    end
  end

  // The product is visible combinationally during DONE and captured as it leaves.
  assign bus.alucontrol = w_alucontrol;
  assign bus.jr         = w_jr;
  assign bus.sign       = w_sign;
  assign bus.illegal    = w_illegal;
  assign bus.stall      = w_stall;
  assign bus.mul_done   = w_mul_done;
  assign bus.mul_result = w_mul_done ? w_prod : r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_mul_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_control_mul_seq
// Brief   : Self-checking bench: decode sweep and randomized multiplies on three builds.
// Revision: 1.0
// ============================================================================
module tb_alu_control_mul_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  aluop = 2'b00;
  logic [5:0]  funct = 6'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  int n_chk = 0;
  int n_err = 0;

  int nn[3]   = '{32, 32, 8};
  bit sgn[3]  = '{1'b1, 1'b0, 1'b0};
  logic [63:0] prev[3];

  always #5 clk = ~clk;

  alu_control_mul_seq_if #(.WIDTH(32)) if_s ();
  alu_control_mul_seq_if #(.WIDTH(32)) if_u ();
  alu_control_mul_seq_if #(.WIDTH(32)) if_u4 ();

  assign if_s.valid_in  = valid;  assign if_s.flush  = flush;  assign if_s.ALUOp  = aluop;
  assign if_s.Funct     = funct;  assign if_s.a      = a;      assign if_s.b      = b;
  assign if_u.valid_in  = valid;  assign if_u.flush  = flush;  assign if_u.ALUOp  = aluop;
  assign if_u.Funct     = funct;  assign if_u.a      = a;      assign if_u.b      = b;
  assign if_u4.valid_in = valid;  assign if_u4.flush = flush;  assign if_u4.ALUOp = aluop;
  assign if_u4.Funct    = funct;  assign if_u4.a     = a;      assign if_u4.b     = b;

  alu_control_mul_seq #(.WIDTH(32), .BITS_PER_CYCLE(1), .SIGNED_MUL(1)) u_dut_s (
    .clk(clk), .reset(reset), .bus(if_s.slave));
  alu_control_mul_seq #(.WIDTH(32), .BITS_PER_CYCLE(1), .SIGNED_MUL(0)) u_dut_u (
    .clk(clk), .reset(reset), .bus(if_u.slave));
  alu_control_mul_seq #(.WIDTH(32), .BITS_PER_CYCLE(4), .SIGNED_MUL(0)) u_dut_u4 (
    .clk(clk), .reset(reset), .bus(if_u4.slave));

  logic [2:0]  st;
  logic [2:0]  dn;
  logic [63:0] res[3];
  assign st = {if_u4.stall, if_u.stall, if_s.stall};
  assign dn = {if_u4.mul_done, if_u.mul_done, if_s.mul_done};
  assign res[0] = if_s.mul_result;
  assign res[1] = if_u.mul_result;
  assign res[2] = if_u4.mul_result;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mul_model(input logic [31:0] x, input logic [31:0] y, input bit s);
    longint p;
    if (s) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return 64'(p);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic logic [6:0] dec_model(input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] c;
    logic       j;
    logic       il;
    c = 4'b0010; j = 1'b0; il = 1'b0;
    if (op == 2'b01) c = 4'b0110;
    else if (op == 2'b11) c = 4'b0000;
    else if (op == 2'b10) begin
      case (fn)
        6'd32: c = 4'b0010;
        6'd34: c = 4'b0110;
        6'd36: c = 4'b0000;
        6'd37: c = 4'b0001;
        6'd39: c = 4'b1100;
        6'd42: c = 4'b0111;
        6'd0:  c = 4'b0011;
        6'd24: c = 4'b1111;
        6'd8:  j = 1'b1;
        default: il = 1'b1;
      endcase
    end
    return {c, j, (op != 2'b11), il};
  endfunction

  // f < 0: no flush; otherwise flush is pulsed f cycles after the request cycle.
  task automatic run_mul(input logic [31:0] ma, input logic [31:0] mb, input int f);
    int sc[3], dc[3], dcyc[3];
    logic [63:0] ex[3];
    bit ab;
    for (int d = 0; d < 3; d++) begin
      sc[d] = 0; dc[d] = 0; dcyc[d] = -1; ex[d] = mul_model(ma, mb, sgn[d]);
    end
    for (int k = 0; k < 46; k++) begin
      @(posedge clk); #1;
      aluop = 2'b10; funct = 6'd24;
      flush = (k == f);
      if (k == 0) begin
        valid = 1'b1; a = ma; b = mb;
      end else begin
        valid = (k <= 8) && (f < 0 || k <= f);
        a = $urandom; b = $urandom;
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        ab = (f >= 0) && (f <= nn[d] + 1);
        if (st[d]) sc[d]++;
        if (dn[d]) begin
          dc[d]++; dcyc[d] = k;
          if (!ab) check_val($sformatf("res_at_done[%0d]", d), res[d], ex[d]);
        end
      end
    end
    valid = 1'b0; flush = 1'b0;
    for (int d = 0; d < 3; d++) begin
      ab = (f >= 0) && (f <= nn[d] + 1);
      check_val($sformatf("stall_cycles[%0d]", d), 64'(sc[d]),
                64'(ab ? (((f < nn[d]) ? f : nn[d]) + 1) : (nn[d] + 1)));
      check_val($sformatf("done_count[%0d]", d), 64'(dc[d]), ab ? 64'd0 : 64'd1);
      if (!ab) begin
        check_val($sformatf("done_cycle[%0d]", d), 64'(dcyc[d]), 64'(nn[d] + 1));
        prev[d] = ex[d];
      end
      check_val($sformatf("res_held[%0d]", d), res[d], prev[d]);
    end
  endtask

  task automatic run_b2b(input logic [31:0] ma, input logic [31:0] mb);
    localparam int L = 68;
    int dc[3], low[3], dsum[3];
    int edc, elow, esum, p;
    logic [63:0] ex[3];
    for (int d = 0; d < 3; d++) begin
      dc[d] = 0; low[d] = 0; dsum[d] = 0; ex[d] = mul_model(ma, mb, sgn[d]);
    end
    for (int k = 0; k < L + 40; k++) begin
      @(posedge clk); #1;
      valid = (k < L); aluop = 2'b10; funct = 6'd24; a = ma; b = mb; flush = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (dn[d]) begin
          dc[d]++; dsum[d] += k;
          check_val($sformatf("b2b_res[%0d]", d), res[d], ex[d]);
        end
        if (k < L && !st[d]) low[d]++;
      end
    end
    valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      p = nn[d] + 2; edc = 0; elow = 0; esum = 0;
      for (int r = 0; r * p < L; r++) begin
        edc++; esum += r * p + nn[d] + 1;
        if (r * p + nn[d] + 1 < L) elow++;
      end
      check_val($sformatf("b2b_done_count[%0d]", d), 64'(dc[d]), 64'(edc));
      check_val($sformatf("b2b_done_cycles[%0d]", d), 64'(dsum[d]), 64'(esum));
      check_val($sformatf("b2b_idle_cycles[%0d]", d), 64'(low[d]), 64'(elow));
      prev[d] = ex[d];
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    for (int d = 0; d < 3; d++) prev[d] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_val($sformatf("rst_stall[%0d]", d), 64'(st[d]), 64'd0);
      check_val($sformatf("rst_done[%0d]", d), 64'(dn[d]), 64'd0);
      check_val($sformatf("rst_result[%0d]", d), res[d], 64'd0);
    end
    @(posedge clk); #1 reset = 1'b0;

    for (int op = 0; op < 4; op++) begin
      for (int fn = 0; fn < 64; fn++) begin
        aluop = 2'(op); funct = 6'(fn); #1;
        check_val($sformatf("decode op=%0d fn=%0d", op, fn),
                  64'({if_s.alucontrol, if_s.jr, if_s.sign, if_s.illegal}),
                  64'(dec_model(2'(op), 6'(fn))));
      end
    end

    run_mul(32'd7, 32'd6, -1);
    run_mul(32'hFFFF_FFFD, 32'd5, -1);
    run_mul(32'h8000_0000, 32'h8000_0000, -1);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    for (int i = 0; i < 10; i++) begin
      ra = $urandom; rb = $urandom;
      run_mul(ra, rb, -1);
    end

    run_mul(32'h1234_5678, 32'h9ABC_DEF0, 10);
    run_mul(32'h0000_0011, 32'h0000_0013, 9);
    run_mul(32'h7FFF_FFFF, 32'h8000_0001, 33);
    run_mul(32'h0000_0005, 32'h0000_0009, 0);
    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      run_mul(ra, rb, int'($urandom_range(1, 40)));
    end

    run_b2b(32'h0001_0003, 32'hFFFF_FFF0);

    // Asynchronous reset while busy
    @(posedge clk); #1;
    valid = 1'b1; aluop = 2'b10; funct = 6'd24; a = 32'hDEAD_BEEF; b = 32'h0000_0777;
    repeat (5) begin
      @(posedge clk); #1 valid = 1'b0;
    end
    #1 reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_val($sformatf("async_rst_stall[%0d]", d), 64'(st[d]), 64'd0);
      check_val($sformatf("async_rst_done[%0d]", d), 64'(dn[d]), 64'd0);
      check_val($sformatf("async_rst_result[%0d]", d), res[d], 64'd0);
      prev[d] = '0;
    end
    @(posedge clk); #1 reset = 1'b0;

    run_mul(32'd7, 32'd6, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
